// File: rtl/mpmc11_burst_seq.sv
// Burst sequencer for a memory-controller front end: issues one command and
// (for writes) one data beat per accepted beat, then reports completion.
module mpmc11_burst_seq #(
    parameter int CNT_W      = 6,
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             we,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             cmd_rdy,
    input  logic             wdf_rdy,
    input  logic             rd_valid,
    output logic             cmd_en,
    output logic             wdf_wren,
    output logic             wdf_end,
    output logic [CNT_W:0]   cmd_cnt,
    output logic [CNT_W:0]   data_cnt,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err_ovr,
    output logic [3:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic             we_q;

    logic [CNT_W:0]   len_ext;
    logic [CNT_W:0]   beats;
    logic             start_acc;
    logic             cmd_fire;
    logic             wdf_fire;
    logic             rd_take;
    logic             err_hit;
    logic             all_done;

    assign len_ext = {1'b0, len_q};
    assign beats   = len_ext + (CNT_W+1)'(1);

    // Handshakes: a command transfers in any cycle where cmd_en & cmd_rdy,
    // a write beat where wdf_wren & wdf_rdy; the two run independently.
    // rd_valid is a push from memory with no back-pressure.
    assign cmd_en   = (state == WR || state == RD) && (cmd_cnt <= len_ext) && !abort;
    assign wdf_wren = (state == WR) && (data_cnt <= len_ext) && !abort;
    assign wdf_end  = wdf_wren && (data_cnt == len_ext);

    assign start_acc = (state == IDLE) && start;
    assign cmd_fire  = cmd_en && cmd_rdy;
    assign wdf_fire  = wdf_wren && wdf_rdy;
    assign rd_take   = rd_valid && (data_cnt < cmd_cnt) && (state == RD || state == DRAIN);
    // A return with no outstanding command is an overrun regardless of state.
    assign err_hit   = rd_valid && (data_cnt >= cmd_cnt);
    assign all_done  = (cmd_cnt == beats) && (data_cnt == beats);

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = {we_q, state};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            len_q    <= '0;
            we_q     <= 1'b0;
            cmd_cnt  <= '0;
            data_cnt <= '0;
            aborted  <= 1'b0;
            err_ovr  <= 1'b0;
        end else begin
            if (ERR_STICKY) begin
                if (start_acc)
                    err_ovr <= 1'b0;
                else if (err_hit)
                    err_ovr <= 1'b1;
            end else begin
                err_ovr <= err_hit;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        we_q     <= we;
                        cmd_cnt  <= '0;
                        data_cnt <= '0;
                        aborted  <= 1'b0;
                        state    <= we ? WR : RD;
                    end
                end
                WR: begin
                    if (cmd_fire)
                        cmd_cnt <= cmd_cnt + (CNT_W+1)'(1);
                    if (wdf_fire)
                        data_cnt <= data_cnt + (CNT_W+1)'(1);
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= DONE;
                    end else if (all_done) begin
                        state <= DONE;
                    end
                end
                RD: begin
                    if (cmd_fire)
                        cmd_cnt <= cmd_cnt + (CNT_W+1)'(1);
                    if (rd_take)
                        data_cnt <= data_cnt + (CNT_W+1)'(1);
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= DRAIN;
                    end else if (all_done) begin
                        state <= DONE;
                    end
                end
                DRAIN: begin
                    // Wait for every issued read to come back before reporting.
                    if (rd_take)
                        data_cnt <= data_cnt + (CNT_W+1)'(1);
                    if (data_cnt == cmd_cnt)
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpmc11_burst_seq.sv
// Bench for mpmc11_burst_seq: spec-level reference model checked every cycle,
// a table of full bursts, hand-written corner sequences and random bursts.
module tb_mpmc11_burst_seq;

    localparam int CNT_W = 6;
    localparam int P_IDLE = 0, P_ACT = 1, P_DRAIN = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic rstn, start, we, abort, cmd_rdy, wdf_rdy, rd_valid;
    logic [CNT_W-1:0] len;

    logic cmd_en, wdf_wren, wdf_end, busy, done, aborted, err_ovr;
    logic [CNT_W:0] cmd_cnt, data_cnt;
    logic [3:0] state_dbg;

    logic p_cmd_en, p_wdf_wren, p_wdf_end, p_busy, p_done, p_aborted, p_err_ovr;
    logic [CNT_W:0] p_cmd_cnt, p_data_cnt;
    logic [3:0] p_state_dbg;

    mpmc11_burst_seq #(.CNT_W(CNT_W), .ERR_STICKY(1'b1)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .we(we), .len(len), .abort(abort),
        .cmd_rdy(cmd_rdy), .wdf_rdy(wdf_rdy), .rd_valid(rd_valid),
        .cmd_en(cmd_en), .wdf_wren(wdf_wren), .wdf_end(wdf_end),
        .cmd_cnt(cmd_cnt), .data_cnt(data_cnt), .busy(busy), .done(done),
        .aborted(aborted), .err_ovr(err_ovr), .state_dbg(state_dbg)
    );

    mpmc11_burst_seq #(.CNT_W(CNT_W), .ERR_STICKY(1'b0)) u_dut_pulse (
        .clk(clk), .rstn(rstn), .start(start), .we(we), .len(len), .abort(abort),
        .cmd_rdy(cmd_rdy), .wdf_rdy(wdf_rdy), .rd_valid(rd_valid),
        .cmd_en(p_cmd_en), .wdf_wren(p_wdf_wren), .wdf_end(p_wdf_end),
        .cmd_cnt(p_cmd_cnt), .data_cnt(p_data_cnt), .busy(p_busy), .done(p_done),
        .aborted(p_aborted), .err_ovr(p_err_ovr), .state_dbg(p_state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int ph;
    bit m_we;
    int m_len, m_cmd, m_data;
    bit m_abt, m_err_s, m_err_p;

    typedef struct {
        bit we;
        int len;
        int exp_cyc;
        int exp_cnt;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = P_IDLE; m_we = 0; m_len = 0; m_cmd = 0; m_data = 0;
        m_abt = 0; m_err_s = 0; m_err_p = 0;
    endtask

    task automatic check_all();
        int act, e_cmd, e_wren, e_end;
        act    = (ph == P_ACT) ? 1 : 0;
        e_cmd  = (act == 1 && m_cmd <= m_len && abort !== 1'b1) ? 1 : 0;
        e_wren = (act == 1 && m_we && m_data <= m_len && abort !== 1'b1) ? 1 : 0;
        e_end  = (e_wren == 1 && m_data == m_len) ? 1 : 0;
        chk("cmd_en", 32'(cmd_en), e_cmd);
        chk("wdf_wren", 32'(wdf_wren), e_wren);
        chk("wdf_end", 32'(wdf_end), e_end);
        chk("busy", 32'(busy), (ph != P_IDLE) ? 1 : 0);
        chk("done", 32'(done), (ph == P_DONE) ? 1 : 0);
        chk("cmd_cnt", 32'(cmd_cnt), m_cmd);
        chk("data_cnt", 32'(data_cnt), m_data);
        chk("aborted", 32'(aborted), 32'(m_abt));
        chk("err_sticky", 32'(err_ovr), 32'(m_err_s));
        chk("err_pulse", 32'(p_err_ovr), 32'(m_err_p));
        chk("pulse_cmd_cnt", 32'(p_cmd_cnt), m_cmd);
        chk("pulse_data_cnt", 32'(p_data_cnt), m_data);
    endtask

    task automatic model_update();
        bit err, fin;
        int c, d;
        if (rstn !== 1'b1) begin
            model_reset();
            return;
        end
        err = rd_valid && (m_data >= m_cmd);
        m_err_p = err;
        if (ph == P_IDLE && start) m_err_s = 0;
        else if (err) m_err_s = 1;
        case (ph)
            P_IDLE: begin
                if (start) begin
                    m_we = we; m_len = int'(len); m_cmd = 0; m_data = 0; m_abt = 0;
                    ph = P_ACT;
                end
            end
            P_ACT: begin
                fin = (m_cmd == m_len + 1) && (m_data == m_len + 1);
                c = m_cmd;
                d = m_data;
                if (!m_we && rd_valid && m_data < m_cmd) d++;
                if (!abort) begin
                    if (cmd_rdy && m_cmd <= m_len) c++;
                    if (m_we && wdf_rdy && m_data <= m_len) d++;
                end
                if (abort) begin
                    m_abt = 1;
                    ph = m_we ? P_DONE : P_DRAIN;
                end else if (fin) begin
                    ph = P_DONE;
                end
                m_cmd = c;
                m_data = d;
            end
            P_DRAIN: begin
                fin = (m_data == m_cmd);
                if (rd_valid && m_data < m_cmd) m_data++;
                if (fin) ph = P_DONE;
            end
            default: ph = P_IDLE;
        endcase
    endtask

    // One clock: compare at the falling edge, advance the model, resume after the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; we = 0; len = '0; abort = 0; cmd_rdy = 0; wdf_rdy = 0; rd_valid = 0;
    endtask

    // Starts a burst with all readies high and reads returned as soon as legal;
    // returns with the DUT in its done cycle (or after the bound).
    task automatic run_burst(input bit w, input int l, output int n);
        start = 1; we = w; len = CNT_W'(l); cmd_rdy = 1; wdf_rdy = 1; rd_valid = 0;
        cycle();
        start = 0;
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            rd_valid = (!m_we && m_data < m_cmd) ? 1'b1 : 1'b0;
            cycle();
            n++;
        end
        rd_valid = 0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            cycle();
            n++;
        end
        chk("wait_done", 32'(done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dones;
        tbl[0] = '{1'b1, 3, 6, 4};
        tbl[1] = '{1'b1, 0, 3, 1};
        tbl[2] = '{1'b1, 63, 66, 64};
        tbl[3] = '{1'b0, 0, 4, 1};
        tbl[4] = '{1'b0, 5, 9, 6};
        tbl[5] = '{1'b1, 10, 13, 11};

        idle_inputs();
        rstn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_cnt", 32'(cmd_cnt), 0);
        chk("rst_err", 32'(err_ovr), 0);
        cycle();
        rstn = 1;
        cycle();

        // table of complete bursts
        for (int i = 0; i < 6; i++) begin
            run_burst(tbl[i].we, tbl[i].len, n);
            chk("tbl_done_cycle", n, tbl[i].exp_cyc);
            chk("tbl_cmd_cnt", 32'(cmd_cnt), tbl[i].exp_cnt);
            chk("tbl_data_cnt", 32'(data_cnt), tbl[i].exp_cnt);
            cycle();
            chk("tbl_back_idle", 32'(busy), 0);
            cycle();
        end

        // write with data held back until all commands are taken
        start = 1; we = 1; len = CNT_W'(2); cmd_rdy = 1; wdf_rdy = 0;
        cycle();
        start = 0;
        repeat (3) cycle();
        chk("wlag_cmd_cnt", 32'(cmd_cnt), 3);
        chk("wlag_data_cnt", 32'(data_cnt), 0);
        wdf_rdy = 1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (done === 1'b1) dones++;
        end
        chk("wlag_done_pulses", dones, 1);
        chk("wlag_data_final", 32'(data_cnt), 3);
        idle_inputs();

        // read with late returns, aborted, then drained
        start = 1; we = 0; len = CNT_W'(7); cmd_rdy = 1;
        cycle();
        start = 0;
        repeat (5) cycle();
        cmd_rdy = 0;
        cycle();
        rd_valid = 1;
        repeat (3) cycle();
        rd_valid = 0;
        chk("rd_no_done", 32'(done), 0);
        abort = 1;
        cycle();
        abort = 0;
        chk("rd_abort_busy", 32'(busy), 1);
        chk("rd_abort_flag", 32'(aborted), 1);
        rd_valid = 1;
        repeat (2) cycle();
        rd_valid = 0;
        wait_done(10);
        chk("drain_aborted", 32'(aborted), 1);
        chk("drain_cmd_cnt", 32'(cmd_cnt), 5);
        chk("drain_data_cnt", 32'(data_cnt), 5);
        cycle();
        cycle();

        // overrun in IDLE, then on a len=3 read
        rd_valid = 1;
        cycle();
        rd_valid = 0;
        chk("ovr_idle_sticky", 32'(err_ovr), 1);
        chk("ovr_idle_pulse", 32'(p_err_ovr), 1);
        cycle();
        chk("ovr_idle_sticky_hold", 32'(err_ovr), 1);
        chk("ovr_idle_pulse_gone", 32'(p_err_ovr), 0);
        run_burst(1'b0, 3, n);
        chk("ovr_rd_cleared", 32'(err_ovr), 0);
        chk("ovr_rd_cycle", n, 7);
        rd_valid = 1;
        cycle();
        rd_valid = 0;
        chk("ovr_rd_err", 32'(err_ovr), 1);
        chk("ovr_rd_cmd_cnt", 32'(cmd_cnt), 4);
        chk("ovr_rd_data_cnt", 32'(data_cnt), 4);
        cycle();

        // reset pulse in the middle of a read
        start = 1; we = 0; len = CNT_W'(5); cmd_rdy = 1;
        cycle();
        start = 0;
        repeat (2) cycle();
        rstn = 0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cmd_en", 32'(cmd_en), 0);
        chk("mid_rst_cmd_cnt", 32'(cmd_cnt), 0);
        chk("mid_rst_done", 32'(done), 0);
        model_reset();
        cycle();
        rstn = 1;
        cycle();
        run_burst(1'b0, 0, n);
        chk("post_rst_cycle", n, 4);
        chk("post_rst_cnt", 32'(data_cnt), 1);
        cycle();

        // random bursts against the model
        for (int b = 0; b < 40; b++) begin
            idle_inputs();
            start = 1;
            we = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? CNT_W'(63) : CNT_W'($urandom_range(0, 15));
            abort = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            cmd_rdy = 1'($urandom_range(0, 1));
            wdf_rdy = 1'($urandom_range(0, 1));
            cycle();
            n = 0;
            while (ph != P_IDLE && n < 400) begin
                start    = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
                cmd_rdy  = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
                wdf_rdy  = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
                abort    = ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0;
                if (m_data < m_cmd)
                    rd_valid = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
                else
                    rd_valid = ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0;
                if (ph == P_DONE) start = 0;
                cycle();
                n++;
            end
            chk("rand_burst_ends", (ph == P_IDLE) ? 1 : 0, 1);
            idle_inputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpmc11_burst_seq.md
MPMC11_BURST_SEQ -- requirements
Module: mpmc11_burst_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 6, giving the burst length field width (maximum burst 2^CNT_W beats).
REQ-002 SHALL have parameter ERR_STICKY, default 1: 1 = err_ovr holds until next accepted start; 0 = err_ovr is a one-cycle pulse.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, burst request pulse.
REQ-006 SHALL have port we, input, 1, burst direction sampled with start (1 = write, 0 = read).
REQ-007 SHALL have port len, input, CNT_W, beats minus one, sampled with start.
REQ-008 SHALL have port abort, input, 1, terminates the active burst.
REQ-009 SHALL have port cmd_rdy, input, 1, memory accepts a command this cycle.
REQ-010 SHALL have port wdf_rdy, input, 1, memory accepts a write-data beat this cycle.
REQ-011 SHALL have port rd_valid, input, 1, memory returns one read beat this cycle.
REQ-012 SHALL have port cmd_en, output, 1, command request.
REQ-013 SHALL have port wdf_wren, output, 1, write-data beat request.
REQ-014 SHALL have port wdf_end, output, 1, marks the last write beat.
REQ-015 SHALL have port cmd_cnt, output, CNT_W+1, commands accepted in this burst.
REQ-016 SHALL have port data_cnt, output, CNT_W+1, data beats accepted (write) or received (read).
REQ-017 SHALL have ports busy, done, aborted and err_ovr, all outputs, 1 bit each.

Function
REQ-018 SHALL implement FSM states IDLE, WR, RD, DRAIN and DONE.
REQ-019 IDLE: start SHALL latch len_q = len and we_q = we, clear both counters, clear aborted (and err_ovr when ERR_STICKY=1), and go to WR if we=1, else RD; start outside IDLE SHALL be ignored.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Counters SHALL be CNT_W+1 bits wide so len_q+1 is representable; len = 2^CNT_W-1 SHALL give 2^CNT_W beats with no wrap.
REQ-022 cmd_en SHALL be asserted in WR and RD while cmd_cnt <= len_q; cmd_cnt SHALL increment on cmd_en & cmd_rdy.
REQ-023 wdf_wren SHALL be asserted in WR while data_cnt <= len_q; data_cnt SHALL increment on wdf_wren & wdf_rdy; wdf_end = wdf_wren & (data_cnt == len_q).
REQ-024 Command and write data SHALL be independent: the two may complete in either order and may both be accepted in the same cycle.
REQ-025 In RD, data_cnt SHALL increment on rd_valid while data_cnt < cmd_cnt.
REQ-026 rd_valid in any state when data_cnt >= cmd_cnt, including IDLE, SHALL NOT change the counters and SHALL set err_ovr.
REQ-027 WR and RD SHALL go to DONE in the cycle after both cmd_cnt and data_cnt equal len_q+1.
REQ-028 abort in WR SHALL drop cmd_en and wdf_wren combinationally, set aborted and go to DONE.
REQ-029 abort in RD SHALL drop cmd_en combinationally, set aborted and go to DRAIN.
REQ-030 DRAIN SHALL keep counting rd_valid and go to DONE once data_cnt == cmd_cnt; if this already holds on entry, it SHALL leave after 1 cycle.
REQ-031 DONE SHALL last exactly one cycle with done=1, then go to IDLE; the counters and aborted SHALL hold their values until the next accepted start.
REQ-032 abort in IDLE, DRAIN or DONE SHALL be ignored; start and abort in the same IDLE cycle SHALL accept the start.
REQ-033 Minimum latency SHALL be: start at cycle 0, first cmd_en at cycle 1; with all ready signals held high, done at cycle len+3 for writes.

Reset
REQ-034 rstn=0 SHALL asynchronously force IDLE and clear cmd_cnt, data_cnt, len_q, we_q, aborted and err_ovr; with the FSM in IDLE, cmd_en, wdf_wren, wdf_end, busy and done SHALL be 0.
REQ-035 Reset mid-burst SHALL abandon the burst with no done pulse; the first start after rstn rises SHALL be accepted normally.
REQ-036 Reset release SHALL be synchronised externally; outputs SHALL be stable from the first clock edge after release.

Verification
REQ-037 Write with len=3, cmd_rdy=wdf_rdy=1 -> 4 cmd_en and 4 wdf_wren beats, wdf_end on the 4th beat, done at cycle 6, cmd_cnt=data_cnt=4.
REQ-038 Write with len=2, wdf_rdy=0 until all commands are accepted -> cmd_cnt=3 with data_cnt=0, then 3 data beats, then a single done pulse.
REQ-039 Read with len=7 and 3 rd_valid beats arriving late -> no done; abort -> DRAIN; remaining returns counted; done with aborted=1 and data_cnt==cmd_cnt.
REQ-040 rd_valid in IDLE, and a 5th rd_valid on a len=3 read -> err_ovr=1, counters unchanged; ERR_STICKY=0 variant -> single-cycle pulse.
REQ-041 len=2^CNT_W-1 write -> cmd_cnt=data_cnt=2^CNT_W at done, no wrap.
REQ-042 rstn low for 1 cycle mid-read -> IDLE immediately, all outputs 0, no done; the following start=1, len=0 read completes normally.
